// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for an N-digit common-anode
//             7-segment display. One external hex-to-segment decoder is shared
//             by all digits: this block presents the current digit's nibble on
//             dec_sel, registers the returned pattern onto seg and strobes one
//             anode per slot. A new display value arrives through a
//             valid/ready handshake. It is applied only at a frame boundary,
//             so a single frame never mixes old and new digits.
//  Ports    : clk         system clock, rising edge
//             rst_n       asynchronous active-low reset
//             upd_valid   producer presents a new display value
//             upd_data    nibble k = digit k (digit 0 = rightmost = [3:0])
//             upd_ready   new value can be accepted
//             dec_sel     nibble sent to the shared decoder
//             dec_seg     decoder pattern {dp,g..a}, active-low
//             seg         registered segment drive, active-low
//             an          anode enables, active-low, at most one low
//             frame_tick  one-cycle pulse on the last cycle of each frame
//  Config   : SEG7_LZB_EN  when defined, enables leading-zero blanking
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int N_DIGITS = 4,      // 2..8
  parameter int PRESCALE = 50000,  // clk cycles per digit slot, > DEADTIME+1
  parameter int DEADTIME = 2       // blanked cycles at slot start, >= 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  input  logic [4*N_DIGITS-1:0]   upd_data,
  output logic                    upd_ready,
  output logic [3:0]              dec_sel,
  input  logic [7:0]              dec_seg,
  output logic [7:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEADTIME);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_DIGITS - 1);

  // State
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [4*N_DIGITS-1:0] shadow_q,  shadow_d;
  logic [4*N_DIGITS-1:0] buf_q,     buf_d;
  logic                  pending_q, pending_d;
  logic [N_DIGITS-1:0]   an_q,      an_d;
  logic [7:0]            seg_q;

  logic                  slot_end;
  logic                  frame_end;
  logic                  xfer;
  logic [N_DIGITS-1:0]   lit_mask;

  assign slot_end  = (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (idx_q == IDX_MAX);
  // A transfer needs an empty buffer, a commit needs a full one, so the two
  // can never happen on the same cycle.
  assign xfer      = upd_valid && !pending_q;

  // --------------------------------------------------------------------------
  // Next-state: prescaler, digit index, handshake buffer and shadow value
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    buf_d     = buf_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (xfer) begin
      buf_d     = upd_data;
      pending_d = 1'b1;
    end else if (frame_end && pending_q) begin
      shadow_d  = buf_q;
      pending_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Digits allowed to light. Built from shadow_d so that the registered
  // anode pattern matches the value being shown in the following cycle.
  // --------------------------------------------------------------------------
`ifdef SEG7_LZB_EN
  // nz_above[k]: digit k or some higher digit is non-zero.
  logic [N_DIGITS-1:1] nz_above;

  for (genvar k = 1; k < N_DIGITS; k++) begin : g_lzb
    if (k == N_DIGITS - 1) begin : g_top
      assign nz_above[k] = |shadow_d[4*k +: 4];
    end else begin : g_mid
      assign nz_above[k] = (|shadow_d[4*k +: 4]) | nz_above[k+1];
    end
  end

  // Digit 0 is always lit so that a zero value still shows "0".
  assign lit_mask = {nz_above, 1'b1};
`else
  assign lit_mask = '1;
`endif

  // Anodes are registered from next-state values so they change glitch-free
  // and stay aligned with cnt_q/idx_q. The blanked head of each slot covers
  // the one-cycle decoder-to-seg register latency.
  always_comb begin
    an_d = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if ((cnt_d >= DEAD_END) && (idx_d == IDX_W'(k)) && lit_mask[k]) begin
        an_d[k] = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      buf_q     <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= 8'hFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      buf_q     <= buf_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= dec_seg;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dec_sel    = shadow_q[{idx_q, 2'b00} +: 4];
  assign upd_ready  = ~pending_q;
  assign frame_tick = frame_end;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Purpose  : Directed self-checking bench for seg7_scan_ctrl with
//             N_DIGITS=4, PRESCALE=8, DEADTIME=2 (8-cycle slots, 32-cycle
//             frames). A behavioural hex decoder closes the dec_sel/dec_seg
//             loop. Anode expectations follow SEG7_LZB_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int N_DIGITS = 4;
  localparam int PRESCALE = 8;
  localparam int DEADTIME = 2;

  logic        clk;
  logic        rst_n;
  logic        upd_valid;
  logic [15:0] upd_data;
  logic        upd_ready;
  logic [3:0]  dec_sel;
  logic [7:0]  dec_seg;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(
    .N_DIGITS (N_DIGITS),
    .PRESCALE (PRESCALE),
    .DEADTIME (DEADTIME)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
    .upd_ready  (upd_ready),
    .dec_sel    (dec_sel),
    .dec_seg    (dec_seg),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low {dp,g..a}; 10..15 show 'E'.
  function automatic logic [7:0] dec7(input logic [3:0] n);
    case (n)
      4'h0: dec7 = 8'hC0;
      4'h1: dec7 = 8'hF9;
      4'h2: dec7 = 8'hA4;
      4'h3: dec7 = 8'hB0;
      4'h4: dec7 = 8'h99;
      4'h5: dec7 = 8'h92;
      4'h6: dec7 = 8'h82;
      4'h7: dec7 = 8'hF8;
      4'h8: dec7 = 8'h80;
      4'h9: dec7 = 8'h90;
      default: dec7 = 8'h86;
    endcase
  endfunction

  assign dec_seg = dec7(dec_sel);

  // Digits expected to light for a given displayed value.
  function automatic logic [3:0] lit_of(input logic [15:0] v);
`ifdef SEG7_LZB_EN
    lit_of[0] = 1'b1;
    for (int k = 1; k < 4; k++) lit_of[k] = |(v >> (4 * k));
`else
    lit_of = 4'hF;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Producer presents data for one cycle (caller ensures ready).
  task automatic send(input logic [15:0] v);
    upd_valid = 1'b1;
    upd_data  = v;
    step();
    upd_valid = 1'b0;
  endtask

  // Checks one complete frame starting at its cycle 0; ends at the next cycle 0.
  task automatic check_frame(input logic [15:0] v, input logic [3:0] lit);
    logic [3:0] nib;
    logic [3:0] exp_an;
    for (int s = 0; s < 4; s++) begin
      nib = v[s*4 +: 4];
      for (int k = 0; k < 8; k++) begin
        exp_an = 4'hF;
        if (k >= DEADTIME && lit[s]) exp_an[s] = 1'b0;
        chk("dec_sel", 32'(dec_sel), 32'(nib));
        chk("an", 32'(an), 32'(exp_an));
        chk("frame_tick", 32'(frame_tick), (s == 3 && k == 7) ? 32'd1 : 32'd0);
        if (k >= 1) chk("seg", 32'(seg), 32'(dec7(nib)));
        step();
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    upd_valid = 1'b0;
    upd_data  = 16'h0000;

    // Reset values
    step();
    step();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_ready", 32'(upd_ready), 32'd1);
    chk("rst_dec_sel", 32'(dec_sel), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;  // cycle 0 from here

    // Free run: anode walk and frame_tick at cycle 31, 63
    check_frame(16'h0000, lit_of(16'h0000));
    check_frame(16'h0000, lit_of(16'h0000));

    // Mid-frame update 1234: not shown until the boundary
    repeat (10) step();
    chk("ready_before_1234", 32'(upd_ready), 32'd1);
    send(16'h1234);
    for (int fc = 11; fc < 31; fc++) begin
      chk("ready_low_1234", 32'(upd_ready), 32'd0);
      chk("old_dec_sel", 32'(dec_sel), 32'd0);
      step();
    end
    chk("tick_commit_1234", 32'(frame_tick), 32'd1);
    chk("ready_at_boundary", 32'(upd_ready), 32'd0);
    step();
    chk("ready_after_commit", 32'(upd_ready), 32'd1);
    check_frame(16'h1234, lit_of(16'h1234));

    // 0042 accepted, then 5678 held while ready is low
    step();
    step();
    send(16'h0042);
    upd_valid = 1'b1;
    upd_data  = 16'h5678;
    for (int fc = 3; fc < 32; fc++) begin
      logic [15:0] cur;
      cur = 16'h1234;
      chk("hold_ready_low", 32'(upd_ready), 32'd0);
      chk("hold_dec_sel", 32'(dec_sel), 32'(cur[(fc/8)*4 +: 4]));
      step();
    end
    chk("ready_first_free", 32'(upd_ready), 32'd1);
    step();  // 5678 taken on that ready cycle
    upd_valid = 1'b0;
    chk("ready_after_5678", 32'(upd_ready), 32'd0);
    for (int fc = 1; fc < 32; fc++) begin
      logic [15:0] cur;
      cur = 16'h0042;
      chk("frame_0042", 32'(dec_sel), 32'(cur[(fc/8)*4 +: 4]));
      step();
    end
    check_frame(16'h5678, lit_of(16'h5678));

    // Transfer on the boundary cycle itself: commits one full frame later
    repeat (31) step();
    chk("tick_simul", 32'(frame_tick), 32'd1);
    chk("ready_simul", 32'(upd_ready), 32'd1);
    send(16'h9ABC);
    chk("ready_low_simul", 32'(upd_ready), 32'd0);
    check_frame(16'h5678, lit_of(16'h5678));
    chk("ready_after_simul", 32'(upd_ready), 32'd1);
    check_frame(16'h9ABC, lit_of(16'h9ABC));

    // Leading-zero values
    send(16'h0007);
    repeat (31) step();
    check_frame(16'h0007, lit_of(16'h0007));
    send(16'h0100);
    repeat (31) step();
    check_frame(16'h0100, lit_of(16'h0100));

    // Reset in slot 2 with a pending value
    step();
    step();
    send(16'h1111);
    chk("pending_before_rst", 32'(upd_ready), 32'd0);
    repeat (16) step();
    chk("an_before_rst", 32'(an), 32'hB);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_tick", 32'(frame_tick), 32'd0);
    chk("mid_rst_dec_sel", 32'(dec_sel), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("ready_after_rst", 32'(upd_ready), 32'd1);
    check_frame(16'h0000, lit_of(16'h0000));
    check_frame(16'h0000, lit_of(16'h0000));
    chk("ready_end", 32'(upd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
